// File: rtl/stb_coalesce_if.sv
// Store-buffer port bundle: store request, load lookup/forwarding, and cache drain.
// The slave side is the buffer; the master side is the pipeline/cache driving it.
interface stb_coalesce_if #(
    parameter int N_LINES   = 4,
    parameter int VA_WIDTH  = 32,
    parameter int REG_WIDTH = 32
);
    localparam int BYTES = REG_WIDTH / 8;
    localparam int CW    = $clog2(N_LINES) + 1;

    logic                 i_st_enable;
    logic [1:0]           i_st_size;
    logic [VA_WIDTH-1:0]  i_st_addr;
    logic [REG_WIDTH-1:0] i_st_data;
    logic                 o_st_stall;
    logic                 o_st_misaligned;

    logic                 i_ld_enable;
    logic [1:0]           i_ld_size;
    logic                 i_ld_unsigned;
    logic [VA_WIDTH-1:0]  i_ld_addr;
    logic                 o_fwd_hit;
    logic                 o_fwd_partial;
    logic [REG_WIDTH-1:0] o_fwd_data;

    logic                 o_drain_valid;
    logic [VA_WIDTH-1:0]  o_drain_addr;
    logic [REG_WIDTH-1:0] o_drain_data;
    logic [BYTES-1:0]     o_drain_mask;
    logic                 i_drain_ready;

    logic [CW-1:0]        o_count;
    logic                 o_empty;

    modport slave (
        input  i_st_enable, i_st_size, i_st_addr, i_st_data,
        output o_st_stall, o_st_misaligned,
        input  i_ld_enable, i_ld_size, i_ld_unsigned, i_ld_addr,
        output o_fwd_hit, o_fwd_partial, o_fwd_data,
        output o_drain_valid, o_drain_addr, o_drain_data, o_drain_mask,
        input  i_drain_ready,
        output o_count, o_empty
    );

    modport master (
        output i_st_enable, i_st_size, i_st_addr, i_st_data,
        input  o_st_stall, o_st_misaligned,
        output i_ld_enable, i_ld_size, i_ld_unsigned, i_ld_addr,
        input  o_fwd_hit, o_fwd_partial, o_fwd_data,
        input  o_drain_valid, o_drain_addr, o_drain_data, o_drain_mask,
        output i_drain_ready,
        input  o_count, o_empty
    );
endinterface

// File: rtl/stb_coalesce.sv
// Coalescing store buffer: word-granular circular queue with byte masks, merging into
// the youngest entry, byte-accurate load forwarding and in-order drain that yields to loads.
module stb_coalesce #(
    parameter int N_LINES   = 4,
    parameter int VA_WIDTH  = 32,
    parameter int REG_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    stb_coalesce_if.slave bus
);
    localparam int BYTES = REG_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int WA    = VA_WIDTH - OFF;
    localparam int PW    = $clog2(N_LINES);
    localparam int CW    = PW + 1;

    logic [N_LINES-1:0]   valid_reg;
    logic [WA-1:0]        waddr_reg [N_LINES];
    logic [REG_WIDTH-1:0] data_reg  [N_LINES];
    logic [BYTES-1:0]     mask_reg  [N_LINES];
    logic [PW-1:0]        head_reg, tail_reg;
    logic [CW-1:0]        count_reg, count_next;

    function automatic logic [BYTES-1:0] size_mask(input logic [1:0] size);
        logic [BYTES-1:0] m;
        m = '0;
        for (int b = 0; b < BYTES; b++)
            if (b < (1 << size)) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic access_bad(input logic [1:0] size, input logic [2:0] lo);
        logic [2:0] align;
        case (size)
            2'd0:    align = 3'b000;
            2'd1:    align = 3'b001;
            2'd2:    align = 3'b011;
            default: align = 3'b111;
        endcase
        return ((size == 2'd3) && (REG_WIDTH == 32)) || (|(lo & align));
    endfunction

    function automatic logic [REG_WIDTH-1:0] lane_expand(input logic [BYTES-1:0] m);
        logic [REG_WIDTH-1:0] e;
        for (int b = 0; b < BYTES; b++) e[b*8 +: 8] = {8{m[b]}};
        return e;
    endfunction

    // ---------------- store path ----------------
    logic [OFF-1:0]       st_off;
    logic [WA-1:0]        st_waddr;
    logic                 st_bad, st_ok;
    logic [BYTES-1:0]     st_mask;
    logic [REG_WIDTH-1:0] st_data_sh, st_wmask;
    logic [PW-1:0]        youngest;
    logic                 drain_valid, drain_fire, full;
    logic                 coalesce_hit, do_coalesce, do_alloc;

    assign st_off     = bus.i_st_addr[OFF-1:0];
    assign st_waddr   = bus.i_st_addr[VA_WIDTH-1:OFF];
    assign st_bad     = access_bad(bus.i_st_size, bus.i_st_addr[2:0]);
    assign st_ok      = bus.i_st_enable && !st_bad;
    assign st_mask    = size_mask(bus.i_st_size) << st_off;
    assign st_data_sh = bus.i_st_data << {st_off, 3'b000};
    assign st_wmask   = lane_expand(st_mask);
    assign youngest   = tail_reg - PW'(1);

    assign drain_valid = (count_reg != '0) && !bus.i_ld_enable;
    assign drain_fire  = drain_valid && bus.i_drain_ready;
    assign full        = (count_reg == CW'(N_LINES));

    // The head entry may be on the cache port this cycle; merging into it would tear the write.
    assign coalesce_hit = (count_reg != '0) && (waddr_reg[youngest] == st_waddr)
                          && !((youngest == head_reg) && drain_valid);
    assign do_coalesce  = st_ok && coalesce_hit;
    assign do_alloc     = st_ok && !coalesce_hit && !full;

    assign bus.o_st_stall      = st_ok && !coalesce_hit && full;
    assign bus.o_st_misaligned = bus.i_st_enable && st_bad;

    always_comb begin
        count_next = count_reg;
        if (do_alloc && !drain_fire)
            count_next = count_reg + CW'(1);
        else if (!do_alloc && drain_fire)
            count_next = count_reg - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_coalesce) begin
                data_reg[youngest] <= (data_reg[youngest] & ~st_wmask) | (st_data_sh & st_wmask);
                mask_reg[youngest] <= mask_reg[youngest] | st_mask;
            end
            if (do_alloc) begin
                valid_reg[tail_reg] <= 1'b1;
                waddr_reg[tail_reg] <= st_waddr;
                data_reg[tail_reg]  <= st_data_sh & st_wmask;
                mask_reg[tail_reg]  <= st_mask;
                tail_reg            <= tail_reg + PW'(1);
            end
            if (drain_fire) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PW'(1);
            end
            count_reg <= count_next;
        end
    end

    // ---------------- load forwarding ----------------
    logic [OFF-1:0]       ld_off;
    logic [WA-1:0]        ld_waddr;
    logic                 ld_ok, fwd_hit;
    logic [BYTES-1:0]     ld_mask, lane_found, supplied;
    logic [N_LINES-1:0]   ent_match;
    logic [REG_WIDTH-1:0] fwd_word, fwd_sh, fwd_ext;
    logic [PW-1:0]        scan_idx;
    logic                 sign_bit;

    assign ld_off   = bus.i_ld_addr[OFF-1:0];
    assign ld_waddr = bus.i_ld_addr[VA_WIDTH-1:OFF];
    assign ld_ok    = bus.i_ld_enable && !access_bad(bus.i_ld_size, bus.i_ld_addr[2:0]);
    assign ld_mask  = size_mask(bus.i_ld_size) << ld_off;

    genvar gi;
    for (gi = 0; gi < N_LINES; gi++) begin : g_ent
        assign ent_match[gi] = valid_reg[gi] && (waddr_reg[gi] == ld_waddr);
    end

    // Scan oldest to youngest so a younger matching byte overrides an older one.
    always_comb begin
        lane_found = '0;
        fwd_word   = '0;
        scan_idx   = head_reg;
        for (int k = 0; k < N_LINES; k++) begin
            scan_idx = head_reg + PW'(k);
            for (int b = 0; b < BYTES; b++) begin
                if (ent_match[scan_idx] && mask_reg[scan_idx][b]) begin
                    lane_found[b]      = 1'b1;
                    fwd_word[b*8 +: 8] = data_reg[scan_idx][b*8 +: 8];
                end
            end
        end
    end

    assign supplied = lane_found & ld_mask;
    assign fwd_hit  = ld_ok && (supplied == ld_mask);
    assign fwd_sh   = fwd_word >> {ld_off, 3'b000};

    always_comb begin
        case (bus.i_ld_size)
            2'd0:    sign_bit = fwd_sh[7];
            2'd1:    sign_bit = fwd_sh[15];
            2'd2:    sign_bit = fwd_sh[31];
            default: sign_bit = fwd_sh[REG_WIDTH-1];
        endcase
        sign_bit = sign_bit && !bus.i_ld_unsigned;
        fwd_ext  = '0;
        for (int i = 0; i < REG_WIDTH; i++)
            fwd_ext[i] = (i < (8 << bus.i_ld_size)) ? fwd_sh[i] : sign_bit;
    end

    assign bus.o_fwd_hit     = fwd_hit;
    assign bus.o_fwd_partial = ld_ok && (|supplied) && !fwd_hit;
    assign bus.o_fwd_data    = fwd_hit ? fwd_ext : '0;

    // ---------------- drain port and status ----------------
    assign bus.o_drain_valid = drain_valid;
    assign bus.o_drain_addr  = drain_valid ? {waddr_reg[head_reg], {OFF{1'b0}}} : '0;
    assign bus.o_drain_data  = drain_valid ? data_reg[head_reg] : '0;
    assign bus.o_drain_mask  = drain_valid ? mask_reg[head_reg] : '0;
    assign bus.o_count       = count_reg;
    assign bus.o_empty       = (count_reg == '0);
endmodule

// File: doc/stb_coalesce.md
Name: stb_coalesce

Overview:
Parametrised successor of the data-memory store buffer. It sits between the MEM stage and the data cache. Committed stores are queued in a circular buffer of word-granular entries with byte masks. A store to the same word as the youngest entry is merged into that entry. Loads receive byte-accurate forwarding, and entries drain in order to the cache through a one-cycle request/ready port that yields to loads.

Parameters:
N_LINES, 4, number of buffer entries (power of two, >=2)
VA_WIDTH, 32, virtual address width
REG_WIDTH, 32, data width in bits (32 or 64); BYTES = REG_WIDTH/8, OFF = log2(BYTES)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_st_enable  in  1  store request this cycle
i_st_size  in  2  00 byte, 01 half, 10 word, 11 double
i_st_addr  in  VA_WIDTH  store byte address
i_st_data  in  REG_WIDTH  store data, right-aligned
o_st_stall  out  1  store not accepted this cycle (buffer full)
o_st_misaligned  out  1  store rejected: misaligned or illegal size
i_ld_enable  in  1  load lookup this cycle (also blocks drain)
i_ld_size  in  2  load size, same encoding
i_ld_unsigned  in  1  zero-extend when 1, sign-extend when 0
i_ld_addr  in  VA_WIDTH  load byte address
o_fwd_hit  out  1  every requested byte is supplied by the buffer
o_fwd_partial  out  1  some but not all requested bytes are buffered
o_fwd_data  out  REG_WIDTH  forwarded data, extended
o_drain_valid  out  1  head entry offered to cache
o_drain_addr  out  VA_WIDTH  head word address (low OFF bits zero)
o_drain_data  out  REG_WIDTH  head entry data, byte lanes as in memory
o_drain_mask  out  BYTES  head byte-enable mask
i_drain_ready  in  1  cache accepts the drain request this cycle
o_count  out  log2(N_LINES)+1  occupied entries
o_empty  out  1  count == 0 (used for fences)

Behaviour:
- Entry state: valid, word address (VA_WIDTH-OFF bits), data[REG_WIDTH], mask[BYTES]. Pointers: head, tail, and count.
- Reset: all valid bits cleared; head = tail = count = 0; all outputs 0 except o_empty = 1. A reset in mid-drain discards all contents; no request is outstanding afterward.
- Store legality: size 11 is illegal when REG_WIDTH = 32. A store is misaligned when addr mod (1<<size) != 0. An illegal or misaligned store sets o_st_misaligned = 1 combinationally and changes no state.
- Lane placement: the store byte mask is (1<<(1<<size))-1 shifted left by addr[OFF-1:0]. Data is shifted left by 8*addr[OFF-1:0].
- Coalesce condition: count > 0, the youngest entry (tail-1) has the same word address, and that entry is not the head while o_drain_valid = 1.
  - When the condition holds, masked bytes overwrite the entry data and mask |= store mask.
  - No allocation occurs and o_st_stall = 0, even when the buffer is full.
- Allocate: when no coalesce and count < N_LINES, the store writes the tail entry, tail wraps modulo N_LINES, and count increments.
- Stall: o_st_stall = 1 when no coalesce and count == N_LINES. This holds even if the head drains in the same cycle; there is no same-cycle bypass of freed space.
- Drain: o_drain_valid = !o_empty && !i_ld_enable, combinational from the head entry.
  - A handshake completes when o_drain_valid && i_drain_ready. On that edge the head is invalidated, head wraps, and count decrements.
  - The cache treats each cycle independently, so valid may drop when a load arrives.
- Simultaneous allocate and drain: count is unchanged and both pointers advance.
- Forwarding is purely combinational, within the same cycle.
  - For each requested byte lane, the youngest valid entry (searching tail-1 back to head) with a matching word address and that mask bit set supplies the byte.
  - o_fwd_hit = 1 when all requested lanes are supplied.
  - o_fwd_partial = 1 when at least one requested lane, but not all, is supplied.
  - o_fwd_data: the supplied bytes are shifted down by addr[OFF-1:0] and extended per size and i_ld_unsigned. It is 0 when o_fwd_hit = 0.
  - A misaligned or illegal load gives hit = 0 and partial = 0.
  - A store arriving in the same cycle is not visible to the lookup.
- Order: drains leave strictly oldest-first. Coalescing never reorders data, because it only targets the youngest entry.

Test Plan:
- Reset, then store word 0xDEADBEEF to 0x100 with no load → count 1. Next cycle o_drain_valid = 1, addr 0x100, mask 1111. After i_drain_ready = 1 for one cycle → o_empty = 1.
- Coalesce byte stores: 0xAA to 0x200 then 0xBB to 0x201, with drain blocked by i_ld_enable = 1 → count stays 1, data 0x0000BBAA, mask 0011.
- Forwarding:
  - Load of the half-word at 0x200 with signed extension, after the previous coalesce → o_fwd_hit = 1, data 0xFFFFBBAA.
  - Word load at 0x200 → o_fwd_partial = 1, o_fwd_hit = 0.
- Fill 4 entries at distinct words with i_drain_ready = 0, then store to a 5th word → o_st_stall = 1 and count stays 4. A store to the youngest entry's word in the same state → accepted (coalesced) with stall = 0.
- Youngest-wins: word 0x11111111 stored at 0x300, a different word in between, then byte 0x22 stored at 0x302 (separate entry) → unsigned word load at 0x300 returns 0x11221111 with hit = 1.
- Misaligned half store to 0x101 → o_st_misaligned = 1 and count unchanged. Assert rst while 3 entries are pending → the next cycle count = 0, o_drain_valid = 0, o_empty = 1.
